// File: rtl/apb_pkg.sv
// Shared widths, FSM state encoding and latched-request payload for the APB master arbiter.
package apb_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } apb_req_t;

endpackage

// File: rtl/apb_master_arb_if.sv
// Requester handshake, response and APB bus signals of the two-requester APB master.
interface apb_master_arb_if;
  import apb_pkg::*;

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic                  req0_write;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic [STRB_WIDTH-1:0] req0_strb;
  logic [STRB_WIDTH-1:0] req1_strb;

  logic [1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;

  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req0_write, req1_write, req0_addr, req1_addr,
           req0_wdata, req1_wdata, req0_strb, req1_strb,
    output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid, req0_write, req1_write, req0_addr, req1_addr,
           req0_wdata, req1_wdata, req0_strb, req1_strb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to i_ptr.
module apb_rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_valid;
    if (&i_valid) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by two requesters: round-robin grant, SETUP/ACCESS sequencing,
// PREADY wait timeout and a one-cycle response pulse to the owning requester.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_master_arb_if.master bus
);

  localparam int unsigned   CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e            r_state, w_state_nxt;
  apb_req_t              r_req, w_req_nxt;
  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_owner, w_owner_nxt;
  logic                  r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]      r_wait_cnt, w_wait_cnt_nxt;
  logic [1:0]            r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_slverr, w_rsp_slverr_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;
  logic [1:0]            w_grant;
  logic [1:0]            w_req_ready;
  logic                  w_done;

  apb_rr_arb2 u_arb (
    .i_valid (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_req_nxt         = r_req;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_owner_nxt       = r_owner;
    w_ptr_nxt         = r_ptr;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_rsp_valid_nxt   = '0;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_slverr_nxt  = r_rsp_slverr;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_req_ready       = '0;
    w_done            = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (!PRESET && (|bus.req_valid)) begin
          w_req_ready     = w_grant;
          w_owner_nxt     = w_grant[1];
          w_ptr_nxt       = ~w_grant[1];
          w_req_nxt.write = w_grant[1] ? bus.req1_write : bus.req0_write;
          w_req_nxt.addr  = w_grant[1] ? bus.req1_addr  : bus.req0_addr;
          w_req_nxt.wdata = w_grant[1] ? bus.req1_wdata : bus.req0_wdata;
          w_req_nxt.strb  = w_grant[1] ? bus.req1_strb  : bus.req0_strb;
          w_psel_nxt      = 1'b1;
          w_penable_nxt   = 1'b0;
          w_state_nxt     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_penable_nxt  = 1'b1;
        w_wait_cnt_nxt = '0;
        w_state_nxt    = ST_ACCESS;
      end
      ST_ACCESS: begin
        // PREADY takes priority over a timeout on the same edge
        if (bus.PREADY) begin
          w_done            = 1'b1;
          w_rsp_rdata_nxt   = r_req.write ? '0 : bus.PRDATA;
          w_rsp_slverr_nxt  = bus.PSLVERR;
          w_rsp_timeout_nxt = 1'b0;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_done            = 1'b1;
          w_rsp_rdata_nxt   = '0;
          w_rsp_slverr_nxt  = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
        if (w_done) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = r_owner ? 2'b10 : 2'b01;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state       <= ST_IDLE;
      r_req         <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_owner       <= 1'b0;
      r_ptr         <= 1'b0;
      r_wait_cnt    <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req         <= w_req_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_owner       <= w_owner_nxt;
      r_ptr         <= w_ptr_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_slverr  <= w_rsp_slverr_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.PSELx       = r_psel;
  assign bus.PENABLE     = r_penable;
  assign bus.PWRITE      = r_req.write;
  assign bus.PADDR       = r_req.addr;
  assign bus.PWDATA      = r_req.wdata;
  assign bus.PSTRB       = r_req.strb;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_slverr  = r_rsp_slverr;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: requesters, a programmable-wait APB slave and a response monitor.
module tb_apb_master_arb;
  import apb_pkg::*;

  localparam int TO = 16;

  typedef struct {
    logic [1:0]  owner;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_arb_if bus();

  apb_master_arb #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference outcome of one transfer given how long the slave stalls
  function automatic exp_t model(input int r, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] s, input int wt,
                                 input logic [31:0] rd, input logic e);
    exp_t x;
    x.owner = (r == 1) ? 2'b10 : 2'b01;
    x.write = w;
    x.addr  = a;
    x.wdata = wd;
    x.strb  = s;
    if (wt < TO) begin
      x.acc    = wt + 1;
      x.rdata  = w ? 32'h0 : rd;
      x.slverr = e;
      x.tmo    = 1'b0;
    end else begin
      x.acc    = TO;
      x.rdata  = 32'h0;
      x.slverr = 1'b1;
      x.tmo    = 1'b1;
    end
    return x;
  endfunction

  // Slave: PREADY rises after slv_wait stalled ACCESS cycles; junk data/error while stalled
  initial begin
    int c;
    c = 0;
    bus.PREADY  = 1'b0;
    bus.PRDATA  = '0;
    bus.PSLVERR = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.PSELx && bus.PENABLE) c++;
      else c = 0;
      if (c > 0 && c > slv_wait) begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = slv_rdata;
        bus.PSLVERR = slv_err;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = $urandom();
        bus.PSLVERR = 1'b1;
      end
    end
  end

  // Monitor: phase lengths, field stability and response comparison
  initial begin
    int          setup_cnt;
    int          acc_cnt;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    exp_t        e;
    setup_cnt = 0;
    acc_cnt   = 0;
    cap_addr  = '0;
    cap_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        setup_cnt = 0;
        acc_cnt   = 0;
      end else begin
        if (bus.PSELx && !bus.PENABLE) begin
          setup_cnt++;
          cap_addr  = bus.PADDR;
          cap_wdata = bus.PWDATA;
          if (sb.size() > 0) begin
            check_eq("paddr", bus.PADDR, sb[0].addr);
            check_eq("pwrite", 32'(bus.PWRITE), 32'(sb[0].write));
            check_eq("pwdata", bus.PWDATA, sb[0].wdata);
            check_eq("pstrb", 32'(bus.PSTRB), 32'(sb[0].strb));
          end
        end
        if (bus.PSELx && bus.PENABLE) begin
          acc_cnt++;
          check_eq("hold_paddr", bus.PADDR, cap_addr);
          check_eq("hold_pwdata", bus.PWDATA, cap_wdata);
        end
        if (bus.rsp_valid != 2'b00) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
          end else begin
            e = sb.pop_front();
            check_eq("rsp_owner", 32'(bus.rsp_valid), 32'(e.owner));
            check_eq("rsp_rdata", bus.rsp_rdata, e.rdata);
            check_eq("rsp_slverr", 32'(bus.rsp_slverr), 32'(e.slverr));
            check_eq("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
            check_eq("access_cycles", 32'(acc_cnt), 32'(e.acc));
            check_eq("setup_cycles", 32'(setup_cnt), 32'h1);
            check_eq("psel_gap", 32'(bus.PSELx), 32'h0);
          end
          setup_cnt = 0;
          acc_cnt   = 0;
        end
      end
    end
  end

  task automatic set_req(input int r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s);
    if (r == 1) begin
      bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = wd; bus.req1_strb = s;
    end else begin
      bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = wd; bus.req0_strb = s;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    check_eq("drain", 32'(sb.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input int wt, input logic [31:0] rd, input logic e);
    logic granted;
    slv_wait  = wt;
    slv_rdata = rd;
    slv_err   = e;
    sb.push_back(model(r, w, a, wd, s, wt, rd, e));
    set_req(r, w, a, wd, s);
    bus.req_valid = (r == 1) ? 2'b10 : 2'b01;
    granted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready[(r == 1) ? 1 : 0]) begin
        granted = 1'b1;
        break;
      end
    end
    check_eq("grant_seen", 32'(granted), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    int n0;
    int n1;

    rst = 1'b1;
    bus.req_valid = 2'b11;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check_eq("rst_psel", 32'(bus.PSELx), 32'h0);
    check_eq("rst_penable", 32'(bus.PENABLE), 32'h0);
    check_eq("rst_pwrite", 32'(bus.PWRITE), 32'h0);
    check_eq("rst_paddr", bus.PADDR, 32'h0);
    check_eq("rst_pwdata", bus.PWDATA, 32'h0);
    check_eq("rst_pstrb", 32'(bus.PSTRB), 32'h0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst_rsp_slverr", 32'(bus.rsp_slverr), 32'h0);
    check_eq("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both requesters held valid: grants alternate 0,1,0,1
    slv_wait  = 0;
    slv_rdata = 32'hCAFE0001;
    slv_err   = 1'b0;
    sb.push_back(model(0, 1'b1, 32'h100, 32'hA0A0A0A0, 4'hF, 0, slv_rdata, 1'b0));
    sb.push_back(model(1, 1'b0, 32'h200, 32'h0,        4'h0, 0, slv_rdata, 1'b0));
    sb.push_back(model(0, 1'b1, 32'h104, 32'hA1A1A1A1, 4'h5, 0, slv_rdata, 1'b0));
    sb.push_back(model(1, 1'b0, 32'h204, 32'h0,        4'h0, 0, slv_rdata, 1'b0));
    set_req(0, 1'b1, 32'h100, 32'hA0A0A0A0, 4'hF);
    set_req(1, 1'b0, 32'h200, 32'h0, 4'h0);
    bus.req_valid = 2'b11;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 60 && (n0 < 2 || n1 < 2); i++) begin
      @(negedge clk);
      g = bus.req_ready;
      @(posedge clk);
      #1;
      if (g[0]) begin
        n0++;
        if (n0 == 2) bus.req_valid[0] = 1'b0;
        else set_req(0, 1'b1, 32'h104, 32'hA1A1A1A1, 4'h5);
      end
      if (g[1]) begin
        n1++;
        if (n1 == 2) bus.req_valid[1] = 1'b0;
        else set_req(1, 1'b0, 32'h204, 32'h0, 4'h0);
      end
    end
    check_eq("rr_grants", 32'(n0 + n1), 32'h4);
    bus.req_valid = 2'b00;
    drain();

    issue(0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0);
    drain();
    issue(1, 1'b0, 32'h24, 32'h0, 4'h0, 3, 32'h12345678, 1'b0);
    drain();
    issue(0, 1'b0, 32'h30, 32'h0, 4'h0, 255, 32'h11111111, 1'b0);
    drain();
    issue(1, 1'b0, 32'h34, 32'h0, 4'h0, TO - 1, 32'h0BADF00D, 1'b0);
    drain();
    issue(1, 1'b0, 32'h38, 32'h0, 4'h0, TO, 32'h22222222, 1'b0);
    drain();
    issue(0, 1'b1, 32'h40, 32'h5555AAAA, 4'h3, 2, 32'hFFFF0000, 1'b1);
    drain();
    issue(1, 1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h87654321, 1'b1);
    drain();

    // Reset in the middle of an ACCESS from req0; pointer must return to req0
    issue(0, 1'b0, 32'h50, 32'h0, 4'h0, 255, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_access_penable", 32'(bus.PENABLE), 32'h1);
    set_req(0, 1'b1, 32'h60, 32'h60606060, 4'hC);
    set_req(1, 1'b1, 32'h64, 32'h64646464, 4'h3);
    bus.req_valid = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    check_eq("ready_in_rst", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    check_eq("abort_psel", 32'(bus.PSELx), 32'h0);
    check_eq("abort_penable", 32'(bus.PENABLE), 32'h0);
    check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_front());
    slv_wait  = 0;
    slv_rdata = 32'h0;
    slv_err   = 1'b0;
    sb.push_back(model(0, 1'b1, 32'h60, 32'h60606060, 4'hC, 0, 32'h0, 1'b0));
    g = 2'b00;
    for (int i = 0; i < 10 && g == 2'b00; i++) begin
      @(negedge clk);
      g = bus.req_ready;
    end
    check_eq("post_rst_grant", 32'(g), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    drain();
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
